// File: rtl/noc_pkt_pkg.sv
// Shared types and NoC header layout for the credit-to-val/rdy packet converter.
package noc_pkt_pkg;

    localparam int NOC_DATA_WIDTH = 64;
    localparam int NOC_LEN_LSB    = 22;
    localparam int NOC_LEN_WIDTH  = 8;

    typedef enum logic {
        HDR  = 1'b0,
        BODY = 1'b1
    } pkt_state_e;

    // Payload length of a header flit: the number of body flits that follow it.
    function automatic logic [NOC_LEN_WIDTH-1:0] noc_flit_len(input logic [NOC_DATA_WIDTH-1:0] flit);
        return NOC_LEN_WIDTH'(flit >> NOC_LEN_LSB);
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Circular flit buffer with registered occupancy; drops a write only when full and not dequeuing.
module noc_flit_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  deq,
    output logic                  drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  enq;

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign deq      = rd_valid && rd_ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign enq      = wr_valid && ((count < CW'(DEPTH)) || deq);
    assign drop     = wr_valid && !enq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            if (enq && !deq)      count <= count + CW'(1);
            else if (!enq && deq) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/noc_credit_to_valrdy_pkt.sv
// Credit-based NoC flits to val/rdy with yummy return and OpenPiton packet framing.
// Optional NOC_CREDIT_PKT_STATS_EN adds flit_cnt / pkt_cnt counters.
//   state | meaning
//   HDR   | head flit is a packet header; its length field sizes the packet
//   BODY  | head flit is payload; rem flits of the packet are still to leave
module noc_credit_to_valrdy_pkt
    import noc_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int LEN_LSB    = NOC_LEN_LSB,
    parameter int LEN_WIDTH  = NOC_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  yummy_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  sop_out,
    output logic                  eop_out,
`ifdef NOC_CREDIT_PKT_STATS_EN
    output logic [31:0]           flit_cnt,
    output logic [31:0]           pkt_cnt,
`endif
    output logic                  overflow_err
);

    pkt_state_e           state, state_nxt;
    logic [LEN_WIDTH-1:0] rem, rem_nxt;
    logic [LEN_WIDTH-1:0] head_len;
    logic                 deq;
    logic                 drop;

    noc_flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (valid_in),
        .wr_data  (data_in),
        .rd_ready (ready_out),
        .rd_valid (valid_out),
        .rd_data  (data_out),
        .deq      (deq),
        .drop     (drop)
    );

    generate
        if (DATA_WIDTH == NOC_DATA_WIDTH && LEN_LSB == NOC_LEN_LSB && LEN_WIDTH == NOC_LEN_WIDTH) begin : g_std_len
            assign head_len = noc_flit_len(data_out);
        end else begin : g_custom_len
            assign head_len = data_out[LEN_LSB +: LEN_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HDR;
            rem          <= '0;
            yummy_out    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            rem          <= rem_nxt;
            yummy_out    <= deq;
            overflow_err <= overflow_err | drop;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        sop_out   = 1'b0;
        eop_out   = 1'b0;
        case (state)
            HDR: begin
                sop_out = valid_out;
                eop_out = valid_out && (head_len == '0);
                if (deq && head_len != '0) begin
                    rem_nxt   = head_len;
                    state_nxt = BODY;
                end
            end
            BODY: begin
                eop_out = valid_out && (rem == LEN_WIDTH'(1));
                if (deq) begin
                    rem_nxt = rem - LEN_WIDTH'(1);
                    if (rem == LEN_WIDTH'(1)) state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

`ifdef NOC_CREDIT_PKT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (deq) begin
            flit_cnt <= flit_cnt + 32'd1;
            if (eop_out) pkt_cnt <= pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_credit_to_valrdy_pkt.sv
// Randomized and directed bench for noc_credit_to_valrdy_pkt against a tagged-queue packet model.
module tb_noc_credit_to_valrdy_pkt;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int LLSB  = 22;
    localparam int LW    = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } flit_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out = 1'b0;
    logic          yummy_out;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          sop_out;
    logic          eop_out;
    logic          overflow_err;
`ifdef NOC_CREDIT_PKT_STATS_EN
    logic [31:0]   flit_cnt;
    logic [31:0]   pkt_cnt;
`endif

    noc_credit_to_valrdy_pkt #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .LEN_LSB    (LLSB),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .yummy_out    (yummy_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .sop_out      (sop_out),
        .eop_out      (eop_out),
`ifdef NOC_CREDIT_PKT_STATS_EN
        .flit_cnt     (flit_cnt),
        .pkt_cnt      (pkt_cnt),
`endif
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Reference state: accepted flits tagged with framing at write time.
    flit_t       q[$];
    int          in_left;
    logic        exp_yummy;
    logic        exp_ovf;
    logic [31:0] exp_flits;
    logic [31:0] exp_pkts;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int len);
        logic [DW-1:0] d;
        d = {$urandom, $urandom};
        d[LLSB +: LW] = LW'(len);
        return d;
    endfunction

    task automatic model_clear();
        q.delete();
        in_left   = 0;
        exp_yummy = 1'b0;
        exp_ovf   = 1'b0;
        exp_flits = '0;
        exp_pkts  = '0;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        flit_t f;
        logic  deq_m;
        logic  acc_m;
        int    len;
        @(negedge clk);
        valid_in  = v;
        data_in   = d;
        ready_out = r;
        #1;
        chk("valid_out", DW'(valid_out), DW'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data_out", data_out, q[0].data);
            chk("sop_out", DW'(sop_out), DW'(q[0].sop));
            chk("eop_out", DW'(eop_out), DW'(q[0].eop));
        end
        chk("yummy_out", DW'(yummy_out), DW'(exp_yummy));
        chk("overflow_err", DW'(overflow_err), DW'(exp_ovf));
`ifdef NOC_CREDIT_PKT_STATS_EN
        chk("flit_cnt", DW'(flit_cnt), DW'(exp_flits));
        chk("pkt_cnt", DW'(pkt_cnt), DW'(exp_pkts));
`endif
        deq_m = (q.size() != 0) && r;
        acc_m = v && ((q.size() < DEPTH) || deq_m);
        if (v && !acc_m) exp_ovf = 1'b1;
        if (deq_m) begin
            exp_flits = exp_flits + 32'd1;
            if (q[0].eop) exp_pkts = exp_pkts + 32'd1;
            void'(q.pop_front());
        end
        if (acc_m) begin
            f.data = d;
            if (in_left == 0) begin
                len     = int'(d[LLSB +: LW]);
                f.sop   = 1'b1;
                f.eop   = (len == 0);
                in_left = len;
            end else begin
                f.sop   = 1'b0;
                f.eop   = (in_left == 1);
                in_left = in_left - 1;
            end
            q.push_back(f);
        end
        exp_yummy = deq_m;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in  = 1'b0;
        ready_out = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_valid_out", DW'(valid_out), '0);
        chk("rst_yummy_out", DW'(yummy_out), '0);
        chk("rst_sop_out", DW'(sop_out), '0);
        chk("rst_eop_out", DW'(eop_out), '0);
        chk("rst_overflow_err", DW'(overflow_err), '0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r);
    endtask

    initial begin
        model_clear();
        do_reset();

        // single-flit packet
        step(1'b1, mk(0), 1'b1);
        idle(3, 1'b1);

        // three-flit packet
        step(1'b1, mk(2), 1'b1);
        step(1'b1, mk(77), 1'b1);
        step(1'b1, mk(5), 1'b1);
        idle(4, 1'b1);

        // back-pressure: four flits held, then released
        step(1'b1, mk(3), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, mk(i), 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);

        // full with simultaneous enqueue and dequeue
        for (int i = 0; i < 4; i++) step(1'b1, mk(0), 1'b0);
        step(1'b1, mk(1), 1'b1);
        step(1'b0, '0, 1'b0);
        idle(6, 1'b1);
        step(1'b1, mk(9), 1'b1);
        idle(2, 1'b1);

        // overflow: fifth flit into a full buffer is dropped
        for (int i = 0; i < 4; i++) step(1'b1, mk(0), 1'b0);
        step(1'b1, mk(0), 1'b0);
        idle(2, 1'b0);
        idle(7, 1'b1);

        // reset in the middle of a len=3 packet
        do_reset();
        step(1'b1, mk(3), 1'b1);
        step(1'b1, mk(200), 1'b1);
        step(1'b0, '0, 1'b1);
        do_reset();
        step(1'b1, mk(0), 1'b1);
        idle(3, 1'b1);

        // randomized traffic with occasional resets
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int i = 0; i < 600; i++) begin
                int len;
                len = ($urandom_range(0, 99) < 85) ? $urandom_range(0, 3) : $urandom_range(0, 255);
                step(($urandom_range(0, 99) < 55), mk(len), ($urandom_range(0, 99) < (blk == 3 ? 40 : 80)));
            end
            idle(8, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
